// File: rtl/read_address_sequencer.sv
// rtl/read_address_sequencer.sv - GCN combination-pass read address walker (optional READ_ADDR_STALL_CNT_EN stall counter)
module read_address_sequencer #(
    parameter int WEIGHT_COLS           = 3,
    parameter int FEATURE_ROWS          = 6,
    parameter int ADDR_WIDTH            = 13,
    parameter int WEIGHT_BASE           = 0,
    parameter int FEATURE_BASE          = 512,
    parameter int COUNTER_WEIGHT_WIDTH  = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1,
    parameter int COUNTER_FEATURE_WIDTH = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             read_ready,
    output logic                             read_valid,
    output logic [ADDR_WIDTH-1:0]            read_address,
    output logic                             read_is_feature,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count,
    output logic [COUNTER_FEATURE_WIDTH-1:0] feature_count,
    output logic                             busy,
    output logic                             done
`ifdef READ_ADDR_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_count
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WEIGHT  = 2'd1;
    localparam logic [1:0] S_FEATURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  W_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] F_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0]            W_BASE = ADDR_WIDTH'(WEIGHT_BASE);
    localparam logic [ADDR_WIDTH-1:0]            F_BASE = ADDR_WIDTH'(FEATURE_BASE);

    // Bad geometry must stop elaboration rather than silently wrap addresses.
    if (WEIGHT_COLS < 1) begin : g_bad_weight_cols
        $error("read_address_sequencer: WEIGHT_COLS must be >= 1");
    end
    if (FEATURE_ROWS < 1) begin : g_bad_feature_rows
        $error("read_address_sequencer: FEATURE_ROWS must be >= 1");
    end
    if ((64'(FEATURE_BASE) + 64'(FEATURE_ROWS) - 64'd1) >= (64'd1 << ADDR_WIDTH)) begin : g_bad_feature_range
        $error("read_address_sequencer: feature range exceeds ADDR_WIDTH");
    end
    if ((64'(WEIGHT_BASE) + 64'(WEIGHT_COLS) - 64'd1) >= (64'd1 << ADDR_WIDTH)) begin : g_bad_weight_range
        $error("read_address_sequencer: weight range exceeds ADDR_WIDTH");
    end

    logic [1:0]                       r_state;
    logic                             r_read_valid;
    logic [ADDR_WIDTH-1:0]            r_read_address;
    logic                             r_read_is_feature;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  r_weight_count;
    logic [COUNTER_FEATURE_WIDTH-1:0] r_feature_count;
    logic                             r_busy;
    logic                             r_done;

    logic [1:0]                       w_next_state;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  w_next_weight_count;
    logic [COUNTER_FEATURE_WIDTH-1:0] w_next_feature_count;
    logic                             w_next_is_feature;
    logic [ADDR_WIDTH-1:0]            w_next_address;
    logic                             w_start_accept;

    assign w_start_accept = (r_state == S_IDLE) && start && !abort;

    always_comb begin
        w_next_state         = r_state;
        w_next_weight_count  = r_weight_count;
        w_next_feature_count = r_feature_count;
        w_next_is_feature    = r_read_is_feature;

        case (r_state)
            S_IDLE: begin
                if (w_start_accept) begin
                    w_next_state         = S_WEIGHT;
                    w_next_weight_count  = '0;
                    w_next_feature_count = '0;
                end
            end
            S_WEIGHT: begin
                if (read_ready) begin
                    w_next_state         = S_FEATURE;
                    w_next_feature_count = '0;
                end
            end
            S_FEATURE: begin
                if (read_ready) begin
                    if (r_feature_count != F_LAST) begin
                        w_next_feature_count = r_feature_count + COUNTER_FEATURE_WIDTH'(1);
                    end else if (r_weight_count != W_LAST) begin
                        w_next_weight_count  = r_weight_count + COUNTER_WEIGHT_WIDTH'(1);
                        w_next_feature_count = '0;
                        w_next_state         = S_WEIGHT;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Abort discards any in-flight transfer and returns to a clean idle.
        if (abort && (r_state != S_IDLE)) begin
            w_next_state         = S_IDLE;
            w_next_weight_count  = '0;
            w_next_feature_count = '0;
            w_next_is_feature    = 1'b0;
        end

        if (w_next_state == S_WEIGHT) begin
            w_next_is_feature = 1'b0;
        end else if (w_next_state == S_FEATURE) begin
            w_next_is_feature = 1'b1;
        end

        w_next_address = w_next_is_feature ? (F_BASE + ADDR_WIDTH'(w_next_feature_count))
                                           : (W_BASE + ADDR_WIDTH'(w_next_weight_count));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_read_valid      <= 1'b0;
            r_read_address    <= '0;
            r_read_is_feature <= 1'b0;
            r_weight_count    <= '0;
            r_feature_count   <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            r_state           <= w_next_state;
            r_read_valid      <= (w_next_state == S_WEIGHT) || (w_next_state == S_FEATURE);
            r_read_address    <= w_next_address;
            r_read_is_feature <= w_next_is_feature;
            r_weight_count    <= w_next_weight_count;
            r_feature_count   <= w_next_feature_count;
            r_busy            <= (w_next_state != S_IDLE);
            r_done            <= (w_next_state == S_DONE);
        end
    end

    assign read_valid      = r_read_valid;
    assign read_address    = r_read_address;
    assign read_is_feature = r_read_is_feature;
    assign weight_count    = r_weight_count;
    assign feature_count   = r_feature_count;
    assign busy            = r_busy;
    assign done            = r_done;

`ifdef READ_ADDR_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_start_accept) begin
            r_stall_count <= '0;
        end else if (r_read_valid && !read_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    // Stall instrumentation is not built in this configuration.
`endif

endmodule

// File: tb/tb_read_address_sequencer.sv
// tb/tb_read_address_sequencer.sv - scoreboard bench for read_address_sequencer (default and 1x1 configurations)
module tb_read_address_sequencer;

    typedef struct {
        int addr;
        int isf;
        int wc;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start0, abort0, rr0;
    logic        rv0, isf0, busy0, done0;
    logic [12:0] addr0;
    logic [1:0]  wc0;
    logic [2:0]  fc0;

    logic        s_reset, s_start, s_abort, rr1;
    logic        rv1, isf1, busy1, done1;
    logic [12:0] addr1;
    logic        wc1, fc1;

`ifdef READ_ADDR_STALL_CNT_EN
    logic [15:0] stall0, stall1;
`endif

    read_address_sequencer dut (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .read_ready(rr0),
        .read_valid(rv0), .read_address(addr0), .read_is_feature(isf0),
        .weight_count(wc0), .feature_count(fc0), .busy(busy0), .done(done0)
`ifdef READ_ADDR_STALL_CNT_EN
        , .stall_count(stall0)
`endif
    );

    read_address_sequencer #(
        .WEIGHT_COLS(1), .FEATURE_ROWS(1), .ADDR_WIDTH(13), .FEATURE_BASE(8191)
    ) dut1 (
        .clk(clk), .reset(s_reset), .start(s_start), .abort(s_abort), .read_ready(rr1),
        .read_valid(rv1), .read_address(addr1), .read_is_feature(isf1),
        .weight_count(wc1), .feature_count(fc1), .busy(busy1), .done(done1)
`ifdef READ_ADDR_STALL_CNT_EN
        , .stall_count(stall1)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void push0(input int a, input int f, input int w, input int c);
        exp_t e;
        e.addr = a; e.isf = f; e.wc = w; e.fc = c;
        q0.push_back(e);
    endfunction

    function automatic void push1(input int a, input int f);
        exp_t e;
        e.addr = a; e.isf = f; e.wc = 0; e.fc = 0;
        q1.push_back(e);
    endfunction

    function automatic void push_pass0();
        for (int w = 0; w < 3; w++) begin
            push0(w, 0, w, 0);
            for (int r = 0; r < 6; r++) push0(512 + r, 1, w, r);
        end
    endfunction

    // Scoreboard monitors: every accepted transfer must match the next expected read.
    always @(negedge clk) begin
        if (rv0 && rr0) begin
            if (q0.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL sb0_unexpected actual=%0d required=none", addr0);
            end else begin
                m0 = q0.pop_front();
                chk("sb0_addr", int'(addr0), m0.addr);
                chk("sb0_isf", int'(isf0), m0.isf);
                chk("sb0_wc", int'(wc0), m0.wc);
                chk("sb0_fc", int'(fc0), m0.fc);
            end
        end
    end

    always @(negedge clk) begin
        if (rv1 && rr1) begin
            if (q1.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL sb1_unexpected actual=%0d required=none", addr1);
            end else begin
                m1 = q1.pop_front();
                chk("sb1_addr", int'(addr1), m1.addr);
                chk("sb1_isf", int'(isf1), m1.isf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr0(input int a, input int w, output bit found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rv0 && (int'(addr0) == a) && (int'(wc0) == w)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) begin
            n_checks++; n_errors++;
            $display("FAIL wait_addr actual=timeout required=%0d", a);
        end
    endtask

    task automatic wait_done0(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_valid"}, int'(rv0), 0);
        chk({tag, "_addr"}, int'(addr0), 0);
        chk({tag, "_isf"}, int'(isf0), 0);
        chk({tag, "_wc"}, int'(wc0), 0);
        chk({tag, "_fc"}, int'(fc0), 0);
        chk({tag, "_busy"}, int'(busy0), 0);
        chk({tag, "_done"}, int'(done0), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1; start0 = 0; abort0 = 0; rr0 = 1;
        s_reset = 1; s_start = 0; s_abort = 0; rr1 = 1;
        tick(); tick();
        @(negedge clk);
        chk_reset0("rst");
        chk("rst1_valid", int'(rv1), 0);
        chk("rst1_busy", int'(busy1), 0);
        tick();
        reset = 0; s_reset = 0;
        tick();

        // Full pass with read_ready high: 21 transfers, done in cycle 22.
        push_pass0();
        start0 = 1; tick(); start0 = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            chk("pass_busy", int'(busy0), 1);
            chk("pass_done", int'(done0), (k == 22) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        chk("pass_idle_busy", int'(busy0), 0);
        chk("pass_idle_valid", int'(rv0), 0);
        chk("pass_q_empty", q0.size(), 0);
        tick();

        // Backpressure while presenting 514.
        push_pass0();
        start0 = 1; tick(); start0 = 0;
        wait_addr0(514, 0, ok);
        if (ok) begin
            rr0 = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("bp_valid", int'(rv0), 1);
                chk("bp_addr", int'(addr0), 514);
                chk("bp_isf", int'(isf0), 1);
                chk("bp_wc", int'(wc0), 0);
                chk("bp_fc", int'(fc0), 2);
                tick();
            end
            rr0 = 1;
        end
        wait_done0(ok);
        chk("bp_done_seen", int'(ok), 1);
`ifdef READ_ADDR_STALL_CNT_EN
        chk("bp_stall_count", int'(stall0), 3);
`endif
        tick(); tick();
        chk("bp_q_empty", q0.size(), 0);

        // Abort while presenting 513 of weight column 1.
        push0(0, 0, 0, 0);
        for (int r = 0; r < 6; r++) push0(512 + r, 1, 0, r);
        push0(1, 0, 1, 0); push0(512, 1, 1, 0); push0(513, 1, 1, 1);
        start0 = 1; tick(); start0 = 0;
        wait_addr0(513, 1, ok);
        abort0 = 1; tick(); abort0 = 0;
        @(negedge clk);
        chk("ab_valid", int'(rv0), 0);
        chk("ab_wc", int'(wc0), 0);
        chk("ab_fc", int'(fc0), 0);
        chk("ab_busy", int'(busy0), 0);
        for (int k = 0; k < 3; k++) begin
            chk("ab_no_done", int'(done0), 0);
            @(negedge clk);
        end
        chk("ab_q_empty", q0.size(), 0);
        tick();

        // Start and abort together in IDLE: stay idle.
        start0 = 1; abort0 = 1; tick(); start0 = 0; abort0 = 0;
        @(negedge clk);
        chk("sa_busy", int'(busy0), 0);
        chk("sa_valid", int'(rv0), 0);
        tick();

        // Fresh start replays the full sequence.
        push_pass0();
        start0 = 1; tick(); start0 = 0;
        wait_done0(ok);
        chk("replay_done_seen", int'(ok), 1);
        tick(); tick();
        chk("replay_q_empty", q0.size(), 0);

        // Reset mid-pass during a stall, with start high during reset.
        push0(0, 0, 0, 0); push0(512, 1, 0, 0); push0(513, 1, 0, 1);
        start0 = 1; tick(); start0 = 0;
        wait_addr0(514, 0, ok);
        rr0 = 0; tick();
        reset = 1; start0 = 1; tick();
        @(negedge clk);
        chk_reset0("mid_rst");
        tick();
        reset = 0; start0 = 0; tick();
        @(negedge clk);
        chk("post_rst_busy", int'(busy0), 0);
        chk("post_rst_valid", int'(rv0), 0);
        chk("rst_q_empty", q0.size(), 0);
        rr0 = 1; tick();

        // 1x1 configuration at the top of the address space; start held high through DONE.
        push1(0, 0); push1(8191, 1); push1(0, 0); push1(8191, 1);
        s_start = 1; tick();
        @(negedge clk);
        chk("s_c1_valid", int'(rv1), 1);
        chk("s_c1_isf", int'(isf1), 0);
        tick();
        @(negedge clk);
        chk("s_c2_valid", int'(rv1), 1);
        chk("s_c2_addr", int'(addr1), 8191);
        tick();
        @(negedge clk);
        chk("s_c3_done", int'(done1), 1);
        chk("s_c3_valid", int'(rv1), 0);
        tick();
        @(negedge clk);
        chk("s_c4_busy", int'(busy1), 0);
        chk("s_c4_done", int'(done1), 0);
        tick();
        s_start = 0;
        @(negedge clk);
        chk("s_c5_valid", int'(rv1), 1);
        chk("s_c5_addr", int'(addr1), 0);
        tick(); tick();
        @(negedge clk);
        chk("s_c7_done", int'(done1), 1);
        tick();
        chk("s_q_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/read_address_sequencer.md
Name: read_address_sequencer

Overview:
- Parametrised successor to the combinational feature/weight read-address mux.
- Autonomously walks the weight-column and feature-row loops of one GCN combination pass.
- Issues one SRAM read address per cycle over a valid/ready handshake: per weight column, one weight read, then FEATURE_ROWS feature reads.
- Sits between the top-level controller (start/done) and the shared feature/weight read port of the input memory.

Parameters:
- WEIGHT_COLS, 3: weight columns per pass; must be >= 1.
- FEATURE_ROWS, 6: feature rows read per weight column; must be >= 1.
- ADDR_WIDTH, 13: read address width.
- WEIGHT_BASE, 0: address of weight column 0.
- FEATURE_BASE, 512: address of feature row 0.
- COUNTER_WEIGHT_WIDTH, max(1,$clog2(WEIGHT_COLS)): weight counter width.
- COUNTER_FEATURE_WIDTH, max(1,$clog2(FEATURE_ROWS)): feature counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a pass when sampled in IDLE.
- abort  input  1  synchronous cancel of the current pass.
- read_ready  input  1  memory accepts the presented address this cycle.
- read_valid  output  1  read_address is valid.
- read_address  output  ADDR_WIDTH  SRAM read address.
- read_is_feature  output  1  1 = feature read, 0 = weight read.
- weight_count  output  COUNTER_WEIGHT_WIDTH  current weight column.
- feature_count  output  COUNTER_FEATURE_WIDTH  current feature row.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset: the synchronous reset (reset sampled high at a clk edge) wins over every other input. After reset: state IDLE; read_valid=0; read_address=0; read_is_feature=0; weight_count=0; feature_count=0; busy=0; done=0.
- Registered outputs: all outputs come from registers. read_address equals the previous combinational mux: FEATURE_BASE+feature_count when read_is_feature, else WEIGHT_BASE+weight_count, computed in ADDR_WIDTH bits.
- Address range check: elaboration fails if FEATURE_BASE+FEATURE_ROWS-1 or WEIGHT_BASE+WEIGHT_COLS-1 is >= 2^ADDR_WIDTH.
- State IDLE: read_valid=0.
  - start=1 -> WEIGHT, with weight_count=0 and feature_count=0.
  - start is ignored in every other state.
- State WEIGHT: read_valid=1, read_is_feature=0.
  - On read_ready -> FEATURE, with feature_count=0.
- State FEATURE: read_valid=1, read_is_feature=1.
  - On read_ready with feature_count < FEATURE_ROWS-1: feature_count+1.
  - On read_ready with feature_count == FEATURE_ROWS-1 and weight_count < WEIGHT_COLS-1: weight_count+1, feature_count=0, -> WEIGHT.
  - On read_ready with feature_count == FEATURE_ROWS-1 and weight_count == WEIGHT_COLS-1: -> DONE.
- State DONE: read_valid=0, done=1 for exactly one cycle, then -> IDLE.
  - Counters hold their final values until the next start.
- Handshake:
  - A transfer occurs on a cycle where read_valid & read_ready.
  - While read_valid=1 and read_ready=0, read_address, read_is_feature and both counters hold stable.
  - read_valid never drops without a transfer, except on abort or reset.
- Throughput: with read_ready held high, one address per cycle and no bubbles. A pass is WEIGHT_COLS*(1+FEATURE_ROWS) transfers plus one DONE cycle.
- Latency: start sampled at edge N -> first read_valid=1 in the cycle after edge N.
- Abort: abort=1 in any non-IDLE state -> IDLE at the next edge.
  - read_valid=0, both counters cleared, no done pulse.
  - A transfer presented in the abort cycle counts as accepted by memory, but the sequencer discards it.
  - abort overrides start. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: stay in IDLE.
- Degenerate sizes: WEIGHT_COLS=1 and/or FEATURE_ROWS=1 must work. With FEATURE_ROWS=1, each WEIGHT state is followed by exactly one FEATURE transfer.

Optional Feature:
- Macro: READ_ADDR_STALL_CNT_EN.
- When defined: adds output stall_count, 16 bits.
  - Cleared on reset and on start accepted.
  - Increments each cycle read_valid=1 and read_ready=0; saturates at 16'hFFFF.
  - Holds its value after DONE and after abort.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, read_ready=1, start pulsed at edge 0:
  - Addresses in order: 0, 512..517, 1, 512..517, 2, 512..517 (21 transfers, one per cycle 1..21).
  - done=1 only in cycle 22; busy=1 for cycles 1..22.
- Backpressure: read_ready=0 for 3 cycles while presenting address 514:
  - Address, read_is_feature and counters hold stable; sequence resumes with 515.
  - With READ_ADDR_STALL_CNT_EN, stall_count=3 at done.
- Abort after the 9th transfer (address 513, weight_count=1):
  - Next cycle: IDLE, read_valid=0, counters=0, no done pulse.
  - A fresh start then replays the full sequence from address 0.
- Reset asserted mid-pass while read_valid=1 and read_ready=0:
  - Next cycle all outputs equal their reset values; start during reset is ignored.
- Parameters WEIGHT_COLS=1, FEATURE_ROWS=1, FEATURE_BASE=8191, ADDR_WIDTH=13:
  - Sequence is 0, 8191, then done.
  - start held high through DONE re-arms only from IDLE.
